// File: rtl/kahan_accum_stream.sv
// Sequential Kahan accumulator: folds a stream of FP elements through one
// kahan_step and hands the compensated (sum, c) pair to the merge stage.

module kahan_fp_add #(
   parameter int E = 5,
   parameter int M = 2
) (
   input  logic [E+M:0] a,
   input  logic [E+M:0] b,
   output logic [E+M:0] y
);
   localparam int SW   = M + 4;
   localparam int EMAX = (1 << E) - 1;

   logic          a_nan, b_nan, a_inf, b_inf;
   logic          a_big, sub, up;
   logic [E+M:0]  big, sml;
   logic [SW-1:0] sig_b, sig_s, aligned, mask, n;
   logic [SW:0]   raw;
   logic [M+1:0]  rnd;
   int            ebig, esml, d, sh, lz, nsh, e;

   always_comb begin
      a_nan = (&a[E+M-1:M]) & (|a[M-1:0]);
      b_nan = (&b[E+M-1:M]) & (|b[M-1:0]);
      a_inf = (&a[E+M-1:M]) & ~(|a[M-1:0]);
      b_inf = (&b[E+M-1:M]) & ~(|b[M-1:0]);

      a_big = a[E+M-1:0] >= b[E+M-1:0];
      big   = a_big ? a : b;
      sml   = a_big ? b : a;
      ebig  = (big[E+M-1:M] == '0) ? 1 : int'(big[E+M-1:M]);
      esml  = (sml[E+M-1:M] == '0) ? 1 : int'(sml[E+M-1:M]);
      sig_b = {|big[E+M-1:M], big[M-1:0], 3'b000};
      sig_s = {|sml[E+M-1:M], sml[M-1:0], 3'b000};

      // align the smaller operand; shifted-out bits collapse into sticky
      d       = ebig - esml;
      sh      = (d > SW) ? SW : d;
      mask    = ~({SW{1'b1}} << sh);
      aligned = sig_s >> sh;
      aligned[0] = aligned[0] | (|(sig_s & mask));

      sub = big[E+M] ^ sml[E+M];
      raw = sub ? ({1'b0, sig_b} - {1'b0, aligned})
                : ({1'b0, sig_b} + {1'b0, aligned});

      e = ebig;
      if (raw[SW]) begin
         n = {raw[SW:2], raw[1] | raw[0]};
         e = e + 1;
      end else begin
         n = raw[SW-1:0];
      end

      lz = SW;
      for (int i = 0; i < SW; i++) begin
         if (n[i]) lz = SW - 1 - i;
      end
      // left shift stops at the subnormal boundary
      nsh = (lz < e - 1) ? lz : e - 1;
      n   = n << nsh;
      e   = e - nsh;

      up  = n[2] & (n[1] | n[0] | n[3]);
      rnd = {1'b0, n[SW-1:3]} + {{(M+1){1'b0}}, up};
      if (rnd[M+1]) begin
         rnd = rnd >> 1;
         e   = e + 1;
      end

      if (raw == '0) begin
         y = {~sub & big[E+M], {(E+M){1'b0}}};
      end else if (e >= EMAX) begin
         y = {big[E+M], {E{1'b1}}, {M{1'b0}}};
      end else begin
         y = {big[E+M], rnd[M] ? e[E-1:0] : {E{1'b0}}, rnd[M-1:0]};
      end

      if (a_nan | b_nan | (a_inf & b_inf & (a[E+M] ^ b[E+M]))) begin
         y = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      end else if (a_inf) begin
         y = a;
      end else if (b_inf) begin
         y = b;
      end
   end
endmodule

module kahan_step #(
   parameter int E   = 5,
   parameter int M   = 2,
   parameter int LAT = 1,
   localparam int W  = 1 + E + M
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] elem_i,
   input  logic [W-1:0] sum_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] sum_o,
   output logic [W-1:0] c_o
);
   logic [W-1:0] y, t, z, cn;

   kahan_fp_add #(.E(E), .M(M)) u_y (
      .a(elem_i), .b({~c_i[W-1], c_i[W-2:0]}), .y(y)
   );
   kahan_fp_add #(.E(E), .M(M)) u_t (
      .a(sum_i), .b(y), .y(t)
   );
   kahan_fp_add #(.E(E), .M(M)) u_z (
      .a(t), .b({~sum_i[W-1], sum_i[W-2:0]}), .y(z)
   );
   kahan_fp_add #(.E(E), .M(M)) u_c (
      .a(z), .b({~y[W-1], y[W-2:0]}), .y(cn)
   );

   if (LAT == 0) begin : g_comb
      assign sum_o = t;
      assign c_o   = cn;
   end else begin : g_pipe
      logic [W-1:0] sp [LAT];
      logic [W-1:0] cp [LAT];
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
               sp[i] <= '0;
               cp[i] <= '0;
            end
         end else begin
            sp[0] <= t;
            cp[0] <= cn;
            for (int i = 1; i < LAT; i++) begin
               sp[i] <= sp[i-1];
               cp[i] <= cp[i-1];
            end
         end
      end
      assign sum_o = sp[LAT-1];
      assign c_o   = cp[LAT-1];
   end
endmodule

module kahan_accum_stream #(
   parameter int EXP_WIDTH_I  = 5,
   parameter int MANT_WIDTH_I = 2,
   parameter int LEN_WIDTH    = 8,
   parameter int STEP_LATENCY = 1,
   localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [LEN_WIDTH-1:0]   len_i,
   input  logic                   elem_valid_i,
   output logic                   elem_ready_o,
   input  logic [BIT_WIDTH_I-1:0] elem_i,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [BIT_WIDTH_I-1:0] sum_o,
   output logic [BIT_WIDTH_I-1:0] c_o,
   output logic                   busy_o
);
   localparam int WW = (STEP_LATENCY > 0) ? $clog2(STEP_LATENCY + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCEPT, WAIT, OUT} state_t;

   state_t                 state_q, state_d;
   logic [LEN_WIDTH-1:0]   len_q, cnt_q;
   logic [WW-1:0]          wcnt_q;
   logic [BIT_WIDTH_I-1:0] sum_r, c_r, elem_r;
   logic [BIT_WIDTH_I-1:0] sum_s, c_s;
   logic [BIT_WIDTH_I-1:0] sum_q, c_q;
   logic                   last;

   kahan_step #(
      .E(EXP_WIDTH_I), .M(MANT_WIDTH_I), .LAT(STEP_LATENCY)
   ) u_step (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .elem_i(elem_r),
      .sum_i (sum_r),
      .c_i   (c_r),
      .sum_o (sum_s),
      .c_o   (c_s)
   );

   assign last = (cnt_q == len_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = (len_i == '0) ? OUT : ACCEPT;
         end
         ACCEPT: begin
            if (elem_valid_i) state_d = WAIT;
         end
         WAIT: begin
            if (wcnt_q == '0) state_d = last ? OUT : ACCEPT;
         end
         OUT: begin
            if (res_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         sum_r   <= '0;
         c_r     <= '0;
         elem_r  <= '0;
         sum_q   <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  len_q <= len_i;
                  cnt_q <= '0;
                  sum_r <= '0;
                  c_r   <= '0;
                  if (len_i == '0) begin
                     sum_q <= '0;
                     c_q   <= '0;
                  end
               end
            end
            ACCEPT: begin
               if (elem_valid_i) begin
                  elem_r <= elem_i;
                  cnt_q  <= cnt_q + 1'b1;
                  wcnt_q <= WW'(STEP_LATENCY);
               end
            end
            WAIT: begin
               if (wcnt_q != '0) begin
                  wcnt_q <= wcnt_q - 1'b1;
               end else begin
                  sum_r <= sum_s;
                  c_r   <= c_s;
                  // result registers load together with the final fold
                  if (last) begin
                     sum_q <= sum_s;
                     c_q   <= c_s;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign elem_ready_o = (state_q == ACCEPT);
   assign res_valid_o  = (state_q == OUT);
   assign busy_o       = (state_q != IDLE);
   assign sum_o        = sum_q;
   assign c_o          = c_q;
endmodule

// File: tb/tb_kahan_accum_stream.sv
// Bench for kahan_accum_stream: E5M2 jobs against a real-valued Kahan model
// with round-to-nearest-even picked from the full code table.

module tb_kahan_accum_stream;
   localparam int LAT = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, ev, rr;
   logic [7:0] len, elem;
   logic       er, rv, busy;
   logic [7:0] sum_w, c_w;

   logic       start0, ev0, rr0;
   logic [7:0] len0, elem0;
   logic       er0, rv0, busy0;
   logic [7:0] sum0, c0;

   int vec  = 0;
   int errs = 0;
   logic [7:0] elems[$];

   always #5 clk = ~clk;

   kahan_accum_stream #(.STEP_LATENCY(LAT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len),
      .elem_valid_i(ev), .elem_ready_o(er), .elem_i(elem),
      .res_valid_o(rv), .res_ready_i(rr), .sum_o(sum_w), .c_o(c_w),
      .busy_o(busy)
   );

   kahan_accum_stream #(.STEP_LATENCY(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .len_i(len0),
      .elem_valid_i(ev0), .elem_ready_o(er0), .elem_i(elem0),
      .res_valid_o(rv0), .res_ready_i(rr0), .sum_o(sum0), .c_o(c0),
      .busy_o(busy0)
   );

   function automatic real fval(input logic [7:0] x);
      real m;
      int  ex;
      ex = int'(x[6:2]);
      if (ex == 0) m = real'(x[1:0]) / 4.0 * (2.0 ** (-14.0));
      else m = (1.0 + real'(x[1:0]) / 4.0) * (2.0 ** real'(ex - 15));
      return x[7] ? -m : m;
   endfunction

   // nearest code, ties to even; 0x7C stands for 2^16 so overflow rounds to inf
   function automatic logic [7:0] rnd8(input real r);
      real mag, bd, dd, v;
      logic [7:0] best;
      mag  = (r < 0.0) ? -r : r;
      best = 8'h00;
      bd   = mag;
      for (int k = 1; k <= 124; k++) begin
         v  = (k == 124) ? 65536.0 : fval(8'(k));
         dd = (v > mag) ? v - mag : mag - v;
         if (dd < bd || (dd == bd && (k % 2) == 0)) begin
            bd   = dd;
            best = 8'(k);
         end
      end
      return {r < 0.0, best[6:0]};
   endfunction

   function automatic logic [7:0] fadd(input logic [7:0] a,
                                       input logic [7:0] b);
      bit  an, bn, ai, bi;
      real r;
      an = (a[6:2] == 5'h1f) && (a[1:0] != 2'b00);
      bn = (b[6:2] == 5'h1f) && (b[1:0] != 2'b00);
      ai = (a[6:2] == 5'h1f) && (a[1:0] == 2'b00);
      bi = (b[6:2] == 5'h1f) && (b[1:0] == 2'b00);
      if (an || bn || (ai && bi && a[7] != b[7])) return 8'h7E;
      if (ai) return a;
      if (bi) return b;
      r = fval(a) + fval(b);
      if (r == 0.0) return (a[7] && b[7]) ? 8'h80 : 8'h00;
      return rnd8(r);
   endfunction

   function automatic logic [15:0] kahan_model(input int n);
      logic [7:0] s, c, y, t;
      s = 8'h00;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         y = fadd(elems[i], c ^ 8'h80);
         t = fadd(s, y);
         c = fadd(fadd(t, s ^ 8'h80), y ^ 8'h80);
         s = t;
      end
      return {s, c};
   endfunction

   task automatic run_job(input int n, input int gap_pct, input int bp_pct,
                          output logic [7:0] s_obs, output logic [7:0] c_obs,
                          output int lat, output int hs, output int bad,
                          output bit tmo, output logic rv_after);
      int idx, since, limit;
      bit done, held;
      logic [7:0] hs_s, hc_s;
      idx = 0; hs = 0; bad = 0; lat = -1; since = 99;
      done = 0; held = 0; s_obs = 8'h00; c_obs = 8'h00;
      hs_s = 8'h00; hc_s = 8'h00;
      start = 1'b1; len = 8'(n); ev = 1'b0; rr = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      limit = n * 12 + 200;
      for (int j = 1; j <= limit && !done; j++) begin
         ev   = (idx < n) && ($urandom_range(99) >= gap_pct);
         elem = (idx < n) ? elems[idx] : 8'h00;
         rr   = ($urandom_range(99) >= bp_pct);
         @(negedge clk);
         since++;
         if (er && (since < LAT + 2 || rv || !busy)) bad++;
         if (er && ev) begin
            idx++;
            hs++;
            since = 0;
         end
         if (rv) begin
            if (lat < 0) lat = j;
            if (held && (sum_w !== hs_s || c_w !== hc_s)) bad++;
            hs_s = sum_w;
            hc_s = c_w;
            held = 1;
            if (rr) begin
               s_obs = sum_w;
               c_obs = c_w;
               done  = 1;
            end
         end
         @(posedge clk); #1;
      end
      tmo = !done;
      ev = 1'b0;
      rr = 1'b0;
      @(negedge clk);
      rv_after = rv;
   endtask

   task automatic test_reset;
      @(negedge clk);
      vec++; if (er !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", er); end
      vec++; if (rv !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", rv); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
      vec++; if (sum_w !== 8'h00) begin errs++; $display("FAIL reset_sum: got %h want 00", sum_w); end
      vec++; if (c_w !== 8'h00) begin errs++; $display("FAIL reset_c: got %h want 00", c_w); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_ones3;
      logic [7:0] s, c;
      logic ra;
      int lat, hs, bad;
      bit tmo;
      elems = {8'h3C, 8'h3C, 8'h3C};
      run_job(3, 0, 0, s, c, lat, hs, bad, tmo, ra);
      vec++; if (tmo) begin errs++; $display("FAIL ones3_timeout: got timeout want result"); end
      vec++; if (s !== 8'h42) begin errs++; $display("FAIL ones3_sum: got %h want 42", s); end
      vec++; if (c !== 8'h00) begin errs++; $display("FAIL ones3_c: got %h want 00", c); end
      vec++; if (lat !== 10) begin errs++; $display("FAIL ones3_latency: got %0d want 10", lat); end
      vec++; if (ra !== 1'b0) begin errs++; $display("FAIL ones3_valid_drop: got %b want 0", ra); end
      vec++; if (hs !== 3) begin errs++; $display("FAIL ones3_handshakes: got %0d want 3", hs); end
      vec++; if (bad !== 0) begin errs++; $display("FAIL ones3_protocol: got %0d want 0", bad); end
   endtask

   task automatic test_round;
      logic [7:0] s, c;
      logic ra;
      int lat, hs, bad;
      bit tmo;
      elems = {8'h44, 8'h34};
      run_job(2, 0, 0, s, c, lat, hs, bad, tmo, ra);
      vec++; if (s !== 8'h44) begin errs++; $display("FAIL round_sum: got %h want 44", s); end
      vec++; if (c !== 8'hB4) begin errs++; $display("FAIL round_c: got %h want b4", c); end
      vec++; if (lat !== 7) begin errs++; $display("FAIL round_latency: got %0d want 7", lat); end
   endtask

   task automatic test_len0;
      int bad;
      bad = 0;
      start = 1'b1; len = 8'h00; rr = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      vec++; if (rv !== 1'b1) begin errs++; $display("FAIL len0_valid: got %b want 1", rv); end
      vec++; if (sum_w !== 8'h00) begin errs++; $display("FAIL len0_sum: got %h want 00", sum_w); end
      vec++; if (c_w !== 8'h00) begin errs++; $display("FAIL len0_c: got %h want 00", c_w); end
      vec++; if (er !== 1'b0) begin errs++; $display("FAIL len0_ready: got %b want 0", er); end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         start = k[0];
         len   = 8'(1 + $urandom_range(9));
         @(negedge clk);
         if (rv !== 1'b1 || sum_w !== 8'h00 || c_w !== 8'h00 || er !== 1'b0) bad++;
      end
      vec++; if (bad !== 0) begin errs++; $display("FAIL len0_stall_stable: got %0d bad cycles want 0", bad); end
      @(posedge clk); #1;
      start = 1'b1; rr = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rr = 1'b0;
      @(negedge clk);
      vec++; if (rv !== 1'b0) begin errs++; $display("FAIL len0_valid_drop: got %b want 0", rv); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL len0_start_ignored: got busy=%b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure_255;
      logic [7:0] s, c;
      logic [15:0] exp_sc;
      logic ra;
      int lat, hs, bad;
      bit tmo;
      elems.delete();
      for (int i = 0; i < 255; i++) elems.push_back(8'h3C);
      exp_sc = kahan_model(255);
      run_job(255, 30, 60, s, c, lat, hs, bad, tmo, ra);
      vec++; if (tmo) begin errs++; $display("FAIL bp255_timeout: got timeout want result"); end
      vec++; if (hs !== 255) begin errs++; $display("FAIL bp255_handshakes: got %0d want 255", hs); end
      vec++; if (bad !== 0) begin errs++; $display("FAIL bp255_protocol: got %0d want 0", bad); end
      vec++; if (s !== exp_sc[15:8]) begin errs++; $display("FAIL bp255_sum: got %h want %h", s, exp_sc[15:8]); end
      vec++; if (c !== exp_sc[7:0]) begin errs++; $display("FAIL bp255_c: got %h want %h", c, exp_sc[7:0]); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] s, c;
      logic [15:0] exp_sc;
      logic ra;
      int n, lat, hs, bad;
      bit tmo;
      for (int jb = 0; jb < 8; jb++) begin
         n = 1 + $urandom_range(15);
         elems.delete();
         for (int i = 0; i < n; i++) elems.push_back(8'($urandom_range(255)));
         exp_sc = kahan_model(n);
         run_job(n, 20, 30, s, c, lat, hs, bad, tmo, ra);
         vec++;
         if (tmo || hs !== n || bad !== 0 || s !== exp_sc[15:8] || c !== exp_sc[7:0]) begin
            errs++;
            $display("FAIL b2b_job%0d: got sum=%h c=%h hs=%0d bad=%0d tmo=%0d want sum=%h c=%h hs=%0d",
                     jb, s, c, hs, bad, tmo, exp_sc[15:8], exp_sc[7:0], n);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] s, c;
      logic ra;
      int lat, hs, bad;
      bit tmo;
      start = 1'b1; len = 8'd4; ev = 1'b0; elem = 8'h3C;
      @(posedge clk); #1;
      start = 1'b0; ev = 1'b1;
      @(posedge clk); #1;
      ev = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      vec++;
      if (er !== 1'b0 || rv !== 1'b0 || busy !== 1'b0 || sum_w !== 8'h00 || c_w !== 8'h00) begin
         errs++;
         $display("FAIL midreset_outputs: got er=%b rv=%b busy=%b sum=%h c=%h want all 0",
                  er, rv, busy, sum_w, c_w);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (rv !== 1'b0 || busy !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      vec++; if (bad !== 0) begin errs++; $display("FAIL midreset_idle: got %0d bad cycles want 0", bad); end
      elems = {8'h40};
      run_job(1, 0, 0, s, c, lat, hs, bad, tmo, ra);
      vec++; if (s !== 8'h40) begin errs++; $display("FAIL midreset_sum: got %h want 40", s); end
      vec++; if (c !== 8'h00) begin errs++; $display("FAIL midreset_c: got %h want 00", c); end
   endtask

   task automatic test_step_lat0;
      int acc[$];
      int idx0, lat, gap;
      bit done;
      logic [7:0] s, c;
      idx0 = 0; lat = -1; done = 0; s = 8'h00; c = 8'h00;
      start0 = 1'b1; len0 = 8'd2;
      @(posedge clk); #1;
      start0 = 1'b0;
      for (int j = 1; j <= 40 && !done; j++) begin
         ev0   = (idx0 < 2);
         elem0 = (idx0 == 0) ? 8'h3C : 8'h40;
         rr0   = 1'b1;
         @(negedge clk);
         if (er0 && ev0) begin
            acc.push_back(j);
            idx0++;
         end
         if (rv0) begin
            s = sum0;
            c = c0;
            lat = j;
            done = 1;
         end
         @(posedge clk); #1;
      end
      ev0 = 1'b0; rr0 = 1'b0;
      gap = (acc.size() == 2) ? acc[1] - acc[0] : -1;
      vec++; if (!done) begin errs++; $display("FAIL lat0_timeout: got timeout want result"); end
      vec++; if (gap !== 2) begin errs++; $display("FAIL lat0_spacing: got %0d want 2", gap); end
      vec++; if (s !== 8'h42) begin errs++; $display("FAIL lat0_sum: got %h want 42", s); end
      vec++; if (c !== 8'h00) begin errs++; $display("FAIL lat0_c: got %h want 00", c); end
      vec++; if (lat !== 5) begin errs++; $display("FAIL lat0_latency: got %0d want 5", lat); end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; len = 8'h00; ev = 1'b0; rr = 1'b0; elem = 8'h00;
      start0 = 1'b0; len0 = 8'h00; ev0 = 1'b0; rr0 = 1'b0; elem0 = 8'h00;
      test_reset();
      test_ones3();
      test_len0();
      test_round();
      test_backpressure_255();
      test_back_to_back();
      test_reset_mid();
      test_step_lat0();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
